hazard_stall_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage pipeline (F/D/E/M/W).
//  - Detects read-after-write hazards between the D-stage instruction and the instructions in E and M, using Tuse/Tnew.
//  - Sequences the multi-cycle mult/div unit.
//  - Drives PC_En, FD_En and DE_Clr: freezes F/D and inserts a bubble into E.
//  - Keeps a stall-cycle counter for performance readout.

---
 rtl/hazard_stall_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: RAW hazard detection via Tuse/Tnew against E and M,
// mult/div busy sequencer, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       D_Rs,
  input  logic [4:0]       D_Rt,
  input  logic [1:0]       D_TuseRs,
  input  logic [1:0]       D_TuseRt,
  input  logic             D_IsMD,
  input  logic [4:0]       DE_RegDst,
  input  logic             DE_RegWrite,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       EM_RegDst,
  input  logic             EM_RegWrite,
  input  logic [1:0]       M_Tnew,
  input  logic             E_MDStart,
  input  logic             E_MDOp,
  output logic             PC_En,
  output logic             FD_En,
  output logic             DE_Clr,
  output logic             Stall,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic [CNT_W-1:0] Stall_Cnt
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MCW     = $clog2(MAX_LAT + 1);
  localparam logic [MCW-1:0] MULT_LOAD = MCW'(MULT_LAT);
  localparam logic [MCW-1:0] DIV_LOAD  = MCW'(DIV_LAT);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [MCW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             md_done;

  logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m, stall_md, stall_raw;

  // A consumer stalls only if it needs the value before the producer can forward it.
  always_comb begin
    stall_rs_e = (D_Rs != 5'd0) && (D_Rs == DE_RegDst) && DE_RegWrite && (D_TuseRs < E_Tnew);
    stall_rs_m = (D_Rs != 5'd0) && (D_Rs == EM_RegDst) && EM_RegWrite && (D_TuseRs < M_Tnew);
    stall_rt_e = (D_Rt != 5'd0) && (D_Rt == DE_RegDst) && DE_RegWrite && (D_TuseRt < E_Tnew);
    stall_rt_m = (D_Rt != 5'd0) && (D_Rt == EM_RegDst) && EM_RegWrite && (D_TuseRt < M_Tnew);
    stall_md   = D_IsMD && ((state_q == MD_BUSY) || E_MDStart);
    stall_raw  = stall_rs_e || stall_rs_m || stall_rt_e || stall_rt_m || stall_md;
  end

  assign Stall  = stall_raw && !Reset;
  assign PC_En  = !Stall;
  assign FD_En  = !Stall;
  assign DE_Clr = Stall;

  // A new start always reloads, so a start coinciding with the final count suppresses MD_Done.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_done  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (E_MDStart) begin
          md_cnt_d = E_MDOp ? DIV_LOAD : MULT_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (E_MDStart) begin
          md_cnt_d = E_MDOp ? DIV_LOAD : MULT_LOAD;
        end else begin
          md_cnt_d = md_cnt_q - MCW'(1);
          if (md_cnt_q == MCW'(1)) begin
            md_done = 1'b1;
            state_d = MD_IDLE;
          end
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
    if (Reset) begin
      state_d  = MD_IDLE;
      md_cnt_d = '0;
      md_done  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Reset) begin
      stall_cnt_d = '0;
    end else if (Stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    state_q     <= state_d;
    md_cnt_q    <= md_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign MD_Busy   = (state_q == MD_BUSY);
  assign MD_Done   = md_done;
  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random traffic, checked
// against a timeline model (start time + latency, stall count since reset).
module tb_hazard_stall_ctrl;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [4:0]    D_Rs, D_Rt, DE_RegDst, EM_RegDst;
  logic [1:0]    D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic          D_IsMD, DE_RegWrite, EM_RegWrite, E_MDStart, E_MDOp;
  logic          PC_En, FD_En, DE_Clr, Stall, MD_Busy, MD_Done;
  logic [CW-1:0] Stall_Cnt;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_IsMD(D_IsMD),
    .DE_RegDst(DE_RegDst), .DE_RegWrite(DE_RegWrite), .E_Tnew(E_Tnew),
    .EM_RegDst(EM_RegDst), .EM_RegWrite(EM_RegWrite), .M_Tnew(M_Tnew),
    .E_MDStart(E_MDStart), .E_MDOp(E_MDOp),
    .PC_En(PC_En), .FD_En(FD_En), .DE_Clr(DE_Clr), .Stall(Stall),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .Stall_Cnt(Stall_Cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md;
    logic [4:0] de_dst;
    logic       de_wr;
    logic [1:0] e_tnew;
    logic [4:0] em_dst;
    logic       em_wr;
    logic [1:0] m_tnew;
    logic       md_start, md_op;
  } stim_t;

  typedef struct packed {
    logic          pc_en, fd_en, de_clr, stall, busy, done;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;

  // Reference timeline: the most recent accepted start and its latency, stall cycles since reset.
  int    cyc = 0;
  int    last_start = -1000;
  int    last_lat = 0;
  int    scnt = 0;
  stim_t prev;
  logic  prev_stall = 1'b0;

  function automatic stim_t base();
    stim_t s = '0;
    s.tuse_rs = 2'd3;
    s.tuse_rt = 2'd3;
    return s;
  endfunction

  function automatic logic hz(logic [4:0] r, logic [1:0] tuse, logic [4:0] dst, logic wr, logic [1:0] tnew);
    return (r != 5'd0) && (r == dst) && wr && (tuse < tnew);
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic busy, haz;
    @(posedge Clk);
    #1;
    cyc++;
    if (prev.rst) begin
      last_start = -1000;
      scnt = 0;
    end else begin
      if (prev.md_start) begin
        last_start = cyc - 1;
        last_lat   = prev.md_op ? 10 : 5;
      end
      if (prev_stall) scnt++;
    end
    Reset = s.rst; D_Rs = s.rs; D_Rt = s.rt; D_TuseRs = s.tuse_rs; D_TuseRt = s.tuse_rt;
    D_IsMD = s.is_md; DE_RegDst = s.de_dst; DE_RegWrite = s.de_wr; E_Tnew = s.e_tnew;
    EM_RegDst = s.em_dst; EM_RegWrite = s.em_wr; M_Tnew = s.m_tnew;
    E_MDStart = s.md_start; E_MDOp = s.md_op;
    busy = (cyc > last_start) && (cyc <= last_start + last_lat);
    haz  = hz(s.rs, s.tuse_rs, s.de_dst, s.de_wr, s.e_tnew) || hz(s.rs, s.tuse_rs, s.em_dst, s.em_wr, s.m_tnew) ||
           hz(s.rt, s.tuse_rt, s.de_dst, s.de_wr, s.e_tnew) || hz(s.rt, s.tuse_rt, s.em_dst, s.em_wr, s.m_tnew);
    e.stall  = !s.rst && (haz || (s.is_md && (busy || s.md_start)));
    e.pc_en  = !e.stall;
    e.fd_en  = !e.stall;
    e.de_clr = e.stall;
    e.busy   = busy;
    e.done   = !s.rst && busy && (cyc == last_start + last_lat) && !s.md_start;
    e.cnt    = (scnt > 15) ? CW'(15) : CW'(scnt);
    e.cyc    = cyc;
    sb.push_back(e);
    prev       = s;
    prev_stall = e.stall;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PC_En",     e.cyc, 32'(PC_En),     32'(e.pc_en));
        chk("FD_En",     e.cyc, 32'(FD_En),     32'(e.fd_en));
        chk("DE_Clr",    e.cyc, 32'(DE_Clr),    32'(e.de_clr));
        chk("Stall",     e.cyc, 32'(Stall),     32'(e.stall));
        chk("MD_Busy",   e.cyc, 32'(MD_Busy),   32'(e.busy));
        chk("MD_Done",   e.cyc, 32'(MD_Done),   32'(e.done));
        chk("Stall_Cnt", e.cyc, 32'(Stall_Cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    s = base();
    s.rst = 1'b1;
    Reset = 1'b1; D_Rs = '0; D_Rt = '0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_IsMD = 1'b0;
    DE_RegDst = '0; DE_RegWrite = 1'b0; E_Tnew = '0; EM_RegDst = '0; EM_RegWrite = 1'b0;
    M_Tnew = '0; E_MDStart = 1'b0; E_MDOp = 1'b0;
    prev = s;
    repeat (2) @(posedge Clk);
    step(s);
    step(base());

    // Load-use, then the producer becomes forwardable.
    s = base(); s.de_dst = 5'd5; s.de_wr = 1'b1; s.e_tnew = 2'd2; s.rs = 5'd5; s.tuse_rs = 2'd1;
    step(s);
    s.e_tnew = 2'd0;
    step(s);

    // $0 never stalls; a non-writing M instruction never stalls.
    s = base(); s.rs = 5'd0; s.de_dst = 5'd0; s.de_wr = 1'b1; s.e_tnew = 2'd2; s.tuse_rs = 2'd0;
    step(s);
    s = base(); s.rt = 5'd7; s.em_dst = 5'd7; s.em_wr = 1'b0; s.m_tnew = 2'd2; s.tuse_rt = 2'd0;
    step(s);

    // Mult with a mult/div instruction waiting in D.
    s = base(); s.is_md = 1'b1; s.md_start = 1'b1; s.md_op = 1'b0;
    step(s);
    s.md_start = 1'b0;
    repeat (7) step(s);

    // Div abandoned by reset.
    s = base(); s.is_md = 1'b1; s.md_start = 1'b1; s.md_op = 1'b1;
    step(s);
    s.md_start = 1'b0;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    repeat (12) step(s);

    // Restart a mult with two cycles left as a div.
    s = base(); s.md_start = 1'b1; s.md_op = 1'b0;
    step(s);
    s.md_start = 1'b0;
    repeat (3) step(s);
    s.md_start = 1'b1; s.md_op = 1'b1;
    step(s);
    s.md_start = 1'b0;
    repeat (12) step(s);

    // Start landing exactly on the final busy cycle.
    s = base(); s.md_start = 1'b1;
    step(s);
    s.md_start = 1'b0;
    repeat (4) step(s);
    s.md_start = 1'b1;
    step(s);
    s.md_start = 1'b0;
    repeat (7) step(s);

    // Counter saturation under a long stall.
    s = base(); s.rst = 1'b1;
    step(s);
    s = base(); s.de_dst = 5'd9; s.de_wr = 1'b1; s.e_tnew = 2'd2; s.rt = 5'd9; s.tuse_rt = 2'd0;
    repeat (20) step(s);
    repeat (3) step(base());

    for (int i = 0; i < 3000; i++) begin
      s = base();
      s.rst      = ($urandom_range(0, 99) == 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.is_md    = ($urandom_range(0, 2) == 0);
      s.de_dst   = 5'($urandom_range(0, 3));
      s.de_wr    = 1'($urandom_range(0, 1));
      s.e_tnew   = 2'($urandom_range(0, 3));
      s.em_dst   = 5'($urandom_range(0, 3));
      s.em_wr    = 1'($urandom_range(0, 1));
      s.m_tnew   = 2'($urandom_range(0, 3));
      s.md_start = ($urandom_range(0, 7) == 0);
      s.md_op    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        s.rs = 5'd0; s.rt = 5'd0;
      end
      step(s);
    end

    repeat (4) @(posedge Clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
